// File: rtl/disp_pkg.sv
// ============================================================================
//  disp_pkg
//  Shared display constants: active-low hex glyph table and blanking values.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam logic [7:0] BLANK  = 8'hFF;
  localparam logic       AN_OFF = 1'b1;

  // Active-low {g,f,e,d,c,b,a} for 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/hex7seg.sv
// ============================================================================
//  hex7seg
//  Combinational nibble to active-low 7-segment glyph decode.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH[i_nib];

endmodule

`default_nettype wire

// File: rtl/disp_scan_mux.sv
// ============================================================================
//  disp_scan_mux
//  Multi-channel, tear-free, time-multiplexed common-anode 7-segment driver.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module disp_scan_mux
  import disp_pkg::*;
#(
  parameter  int CHANNELS     = 8,
  parameter  int DIGITS       = 8,
  parameter  int SCAN_DIV     = 16,
  parameter  int BLINK_DIV    = 25,
  parameter  int DWELL_FRAMES = 256,
  localparam int c_CW         = $clog2(CHANNELS)
)(
  input  logic                         clk,
  input  logic                         RSTN,
  input  logic                         en,
  input  logic                         auto_mode,
  input  logic [c_CW-1:0]              sel,
  input  logic [CHANNELS*DIGITS*4-1:0] data_in,
  input  logic [CHANNELS*DIGITS-1:0]   point_in,
  input  logic [CHANNELS*DIGITS-1:0]   blink_in,
  output logic [7:0]                   seg,
  output logic [DIGITS-1:0]            an,
  output logic [4*DIGITS-1:0]          disp_num,
  output logic [c_CW-1:0]              cur_chan
);

  localparam int c_DW  = $clog2(DIGITS);
  localparam int c_DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [c_DW-1:0]  c_DIG_LAST = c_DW'(DIGITS - 1);
  localparam logic [c_CW-1:0]  c_CH_LAST  = c_CW'(CHANNELS - 1);
  localparam logic [c_DWW-1:0] c_DW_LAST  = c_DWW'(DWELL_FRAMES - 1);

  logic [SCAN_DIV-1:0]  r_pre;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic                 r_blink_ph;
  logic [c_DW-1:0]      r_dig;
  logic [c_DWW-1:0]     r_dw;
  logic [c_CW-1:0]      r_cur_chan;
  logic [4*DIGITS-1:0]  r_disp_num;
  logic [DIGITS-1:0]    r_pt_mask;
  logic [DIGITS-1:0]    r_bl_mask;
  logic                 r_auto_q;
  logic                 r_lit;
  logic [7:0]           r_seg;
  logic [DIGITS-1:0]    r_an;

  logic                 w_tick;
  logic                 w_frame;
  logic                 w_mode_chg;
  logic [c_CW-1:0]      w_sel_clamp;
  logic [c_CW-1:0]      w_next_chan;
  logic [c_DWW-1:0]     w_next_dw;
  logic [DIGITS-1:0]    w_an;
  logic [6:0]           w_glyph;

  always_comb begin
    w_tick      = en && (r_pre == '1);
    w_frame     = w_tick && (r_dig == c_DIG_LAST);
    w_mode_chg  = (auto_mode != r_auto_q);
    w_sel_clamp = (int'(sel) >= CHANNELS) ? '0 : sel;
    w_next_chan = r_cur_chan;
    w_next_dw   = r_dw;

    if (w_mode_chg) begin
      w_next_dw = '0;
    end

    // A mode toggle coinciding with a boundary suppresses the dwell step.
    if (w_frame) begin
      if (!auto_mode) begin
        w_next_chan = w_sel_clamp;
      end else if (!w_mode_chg) begin
        if (r_dw == c_DW_LAST) begin
          w_next_dw   = '0;
          w_next_chan = (r_cur_chan == c_CH_LAST) ? '0 : r_cur_chan + 1'b1;
        end else begin
          w_next_dw = r_dw + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_an = {DIGITS{AN_OFF}};
    if (!(r_bl_mask[r_dig] && r_blink_ph)) begin
      w_an[r_dig] = 1'b0;
    end
  end

  hex7seg u_hex7seg (
    .i_nib (r_disp_num[{r_dig, 2'b00} +: 4]),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_pre       <= '0;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_dig       <= '0;
      r_dw        <= '0;
      r_cur_chan  <= '0;
      r_disp_num  <= '0;
      r_pt_mask   <= '0;
      r_bl_mask   <= '0;
      r_auto_q    <= 1'b0;
      r_lit       <= 1'b0;
      r_seg       <= BLANK;
      r_an        <= {DIGITS{AN_OFF}};
    end else begin
      r_auto_q <= auto_mode;
      r_dw     <= w_next_dw;

      if (en) begin
        r_pre       <= r_pre + 1'b1;
        r_blink_cnt <= r_blink_cnt + 1'b1;
        if (r_blink_cnt == '1) begin
          r_blink_ph <= ~r_blink_ph;
        end
        if (w_tick) begin
          r_dig <= (r_dig == c_DIG_LAST) ? '0 : r_dig + 1'b1;
          r_lit <= 1'b1;
        end
        if (w_frame) begin
          r_cur_chan <= w_next_chan;
          r_disp_num <= data_in[int'(w_next_chan)*4*DIGITS +: 4*DIGITS];
          r_pt_mask  <= point_in[int'(w_next_chan)*DIGITS +: DIGITS];
          r_bl_mask  <= blink_in[int'(w_next_chan)*DIGITS +: DIGITS];
        end
      end

      // Digits stay dark until the first tick has stepped the scan.
      if (en && r_lit) begin
        r_an  <= w_an;
        r_seg <= {~r_pt_mask[r_dig], w_glyph};
      end else begin
        r_an  <= {DIGITS{AN_OFF}};
        r_seg <= BLANK;
      end
    end
  end

  assign seg      = r_seg;
  assign an       = r_an;
  assign disp_num = r_disp_num;
  assign cur_chan = r_cur_chan;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_mux.sv
// ============================================================================
//  tb_disp_scan_mux
//  Scoreboard bench: directed stimulus queues expectations per cycle.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_disp_scan_mux;

  localparam int K_AN   = 0;
  localparam int K_SEG  = 1;
  localparam int K_CHAN = 2;
  localparam int K_DISP = 3;

  logic         clk       = 1'b0;
  logic         RSTN      = 1'b0;
  logic         en        = 1'b1;
  logic         auto_mode = 1'b0;
  logic [1:0]   sel       = 2'd2;
  logic [127:0] data_in;
  logic [31:0]  point_in;
  logic [31:0]  blink_in;
  logic [7:0]   seg;
  logic [7:0]   an;
  logic [31:0]  disp_num;
  logic [1:0]   cur_chan;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  logic [31:0] m_got;

  disp_scan_mux #(
    .CHANNELS     (4),
    .DIGITS       (8),
    .SCAN_DIV     (2),
    .BLINK_DIV    (4),
    .DWELL_FRAMES (2)
  ) dut (
    .clk       (clk),
    .RSTN      (RSTN),
    .en        (en),
    .auto_mode (auto_mode),
    .sel       (sel),
    .data_in   (data_in),
    .point_in  (point_in),
    .blink_in  (blink_in),
    .seg       (seg),
    .an        (an),
    .disp_num  (disp_num),
    .cur_chan  (cur_chan)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input int k, input logic [31:0] v, input string nm);
    sb.push_back('{c, k, v, nm});
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      n_checks++;
      if (m_e.cyc < cyc) begin
        n_errors++;
        $display("FAIL %s missed at cyc %0d (due %0d)", m_e.name, cyc, m_e.cyc);
      end else begin
        case (m_e.kind)
          K_AN:    m_got = {24'h0, an};
          K_SEG:   m_got = {24'h0, seg};
          K_CHAN:  m_got = {30'h0, cur_chan};
          default: m_got = disp_num;
        endcase
        if (m_got !== m_e.exp) begin
          n_errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", m_e.name, cyc, m_got, m_e.exp);
        end
      end
    end
  end

  initial begin
    data_in  = {32'h13579BDF, 32'h89ABCDEF, 32'hFEDCBA98, 32'h01234567};
    point_in = 32'h0008_0000;   // channel 2, digit 3
    blink_in = 32'h0028_0000;   // channel 2, digits 3 and 5

    // Reset state, first lit digit, manual select, blink/point
    expect_at(3,  K_AN,   32'hFF,       "rst_an");
    expect_at(3,  K_SEG,  32'hFF,       "rst_seg");
    expect_at(3,  K_CHAN, 32'd0,        "rst_chan");
    expect_at(3,  K_DISP, 32'h0,        "rst_disp");
    expect_at(7,  K_AN,   32'hFF,       "pre_first_tick_an");
    expect_at(8,  K_AN,   32'hFD,       "first_lit_an");
    expect_at(8,  K_SEG,  32'hC0,       "first_lit_seg");
    expect_at(34, K_DISP, 32'h0,        "pre_boundary_disp");
    expect_at(34, K_CHAN, 32'd0,        "pre_boundary_chan");
    expect_at(35, K_DISP, 32'h89ABCDEF, "manual_disp");
    expect_at(35, K_CHAN, 32'd2,        "manual_chan");
    expect_at(36, K_AN,   32'hFE,       "dig0_an");
    expect_at(36, K_SEG,  32'h8E,       "dig0_seg");
    expect_at(48, K_AN,   32'hF7,       "dig3_an_ph0");
    expect_at(48, K_SEG,  32'h46,       "dig3_seg_point");
    expect_at(56, K_AN,   32'hFF,       "dig5_blink_an");
    expect_at(64, K_AN,   32'h7F,       "dig7_an");
    expect_at(64, K_SEG,  32'h80,       "dig7_seg");

    wait_cyc(3);
    RSTN = 1'b1;

    // Tear-free snapshot: channel 2 changes mid-frame
    wait_cyc(43);
    data_in[64 +: 32] = 32'h0;
    expect_at(66, K_DISP, 32'h89ABCDEF, "tear_hold_disp");
    expect_at(67, K_DISP, 32'h0,        "tear_new_disp");
    expect_at(67, K_CHAN, 32'd2,        "tear_chan");
    expect_at(68, K_AN,   32'hFE,       "tear_dig0_an");
    expect_at(68, K_SEG,  32'hC0,       "tear_dig0_seg");

    // Auto rotate from channel 2, two frames per channel
    wait_cyc(73);
    auto_mode = 1'b1;
    expect_at(99,  K_CHAN, 32'd2,        "auto_dwell_hold");
    expect_at(130, K_CHAN, 32'd2,        "auto_before_adv");
    expect_at(131, K_CHAN, 32'd3,        "auto_to3");
    expect_at(131, K_DISP, 32'h13579BDF, "auto_to3_disp");
    expect_at(132, K_AN,   32'hFE,       "auto_ch3_dig0_an");
    expect_at(132, K_SEG,  32'h8E,       "auto_ch3_dig0_seg");
    expect_at(195, K_CHAN, 32'd0,        "auto_wrap_to0");
    expect_at(195, K_DISP, 32'h01234567, "auto_to0_disp");
    expect_at(259, K_CHAN, 32'd1,        "auto_to1");
    expect_at(259, K_DISP, 32'hFEDCBA98, "auto_to1_disp");
    expect_at(323, K_CHAN, 32'd2,        "auto_to2");
    expect_at(323, K_DISP, 32'h0,        "auto_to2_disp");

    // Mode toggles while dw=1 must clear the dwell count
    wait_cyc(363);
    auto_mode = 1'b0;
    expect_at(387, K_CHAN, 32'd2, "modesw_no_adv");
    expect_at(419, K_CHAN, 32'd3, "modesw_late_adv");
    wait_cyc(365);
    auto_mode = 1'b1;

    // Enable freeze for 10 clocks with dw=1 and dig=1
    wait_cyc(455);
    en = 1'b0;
    expect_at(456, K_AN,   32'hFF,       "frz_first_an");
    expect_at(456, K_SEG,  32'hFF,       "frz_first_seg");
    expect_at(465, K_AN,   32'hFF,       "frz_last_an");
    expect_at(465, K_SEG,  32'hFF,       "frz_last_seg");
    expect_at(465, K_CHAN, 32'd3,        "frz_chan");
    expect_at(465, K_DISP, 32'h13579BDF, "frz_disp");
    expect_at(466, K_AN,   32'hFD,       "resume_dig1_an");
    expect_at(466, K_SEG,  32'hA1,       "resume_dig1_seg");
    expect_at(470, K_AN,   32'hFB,       "resume_dig2_an");
    expect_at(470, K_SEG,  32'h83,       "resume_dig2_seg");
    expect_at(492, K_CHAN, 32'd3,        "resume_before_adv");
    expect_at(493, K_CHAN, 32'd0,        "resume_adv");
    expect_at(493, K_DISP, 32'h01234567, "resume_adv_disp");
    wait_cyc(465);
    en = 1'b1;

    while (sb.size() > 0 && cyc < 600) @(negedge clk);
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL %s never checked (due cyc %0d)", m_e.name, m_e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
